// File: rtl/select4_rr.sv
// Round-robin arbiter that drives sel/valid for a downstream 4:1 selector, with a bounded dwell per grant.
// Latency: a request sampled at edge t is granted at t+1. All outputs come straight from flops.
// Backpressure: the consumer ends a grant early with release_in. Grants hand over back-to-back with no idle cycle.
//
// Ports:
//   clk, rst_n  - clock; asynchronous active-low reset
//   en          - arbitration enable. Dropping it ends the live grant.
//   req[3:0]    - request lines. Bit i asks for selector input i.
//   release_in  - one-cycle pulse from the consumer that ends the current grant
//   sel[1:0]    - select index for the 4:1 selector. Holds its last value while idle.
//   valid       - sel is a live grant
//   gnt[3:0]    - one-hot copy of sel while valid, otherwise 0
//   hold_cnt    - cycles elapsed in the current grant, 0..MAX_HOLD-1
module select4_rr #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] req,
  input  logic       release_in,
  output logic [1:0] sel,
  output logic       valid,
  output logic [3:0] gnt,
  output logic [3:0] hold_cnt
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] sel_q, sel_d;
  logic       valid_q, valid_d;
  logic [3:0] gnt_q, gnt_d;
  logic [3:0] hold_q, hold_d;

  logic [1:0] pick_base;
  logic [1:0] winner;
  logic       grant_end;

  // Search ptr+1, ptr+2, ptr+3, then ptr itself. The last-granted index
  // therefore loses ties, but it still wins when it is the only requester.
  function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [3:0] r);
    logic [1:0] win;
    logic [1:0] idx;
    logic       found;
    win   = last;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = last + 2'(i);
      if (!found && r[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    valid_d   = valid_q;
    gnt_d     = gnt_q;
    hold_d    = hold_q;

    // A grant that is ending updates ptr to sel in the same cycle. Search
    // from sel so that the same-cycle re-arbitration already sees the new ptr.
    pick_base = (state_q == GRANT) ? sel_q : ptr_q;
    winner    = rr_pick(pick_base, req);
    grant_end = release_in || !req[sel_q] || (hold_q == HOLD_LAST) || !en;

    case (state_q)
      IDLE: begin
        if (en && (|req)) begin
          state_d = GRANT;
          sel_d   = winner;
          gnt_d   = 4'b0001 << winner;
          valid_d = 1'b1;
          hold_d  = 4'd0;
        end
      end
      GRANT: begin
        if (!grant_end) begin
          hold_d = hold_q + 4'd1;
        end else begin
          ptr_d = sel_q;
          if (en && (|req)) begin
            sel_d   = winner;
            gnt_d   = 4'b0001 << winner;
            valid_d = 1'b1;
            hold_d  = 4'd0;
          end else begin
            // sel is left alone so the selector input does not move while idle.
            state_d = IDLE;
            valid_d = 1'b0;
            gnt_d   = 4'd0;
            hold_d  = 4'd0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        gnt_d   = 4'd0;
        hold_d  = 4'd0;
      end
    endcase
  end

  // ptr resets to 3 so that index 0 has first priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 2'd3;
      sel_q   <= 2'd0;
      valid_q <= 1'b0;
      gnt_q   <= 4'd0;
      hold_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      gnt_q   <= gnt_d;
      hold_q  <= hold_d;
    end
  end

  assign sel      = sel_q;
  assign valid    = valid_q;
  assign gnt      = gnt_q;
  assign hold_cnt = hold_q;

endmodule
